// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32I elastic pipeline registers.
// - occ_t       : occupancy of a pipe_stage_reg instance (EMPTY / ONE / FULL).
// - NOP_INSTR   : addi x0,x0,0, used as the bubble payload for instruction bundles.
// - fd_t..mw_t  : packed stage bundles; instances use DATA_WIDTH = $bits(<bundle>).
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fd_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
    } de_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
    } em_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        reg_we;
    } mw_t;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter, shared by the pipeline performance monitors.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, clears the count
//   inc   : count one event this cycle
//   count : current count, sticks at all-ones
module sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] count_q;

    // Count register: increments on inc until it reaches all-ones, then holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {CNT_WIDTH{1'b0}};
        end else if (inc && (count_q != CNT_MAX)) begin
            count_q <= count_q + CNT_ONE;
        end else begin
            count_q <= count_q;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register placed between two RV32I stages.
// Ports:
//   clk, rst              : clock and asynchronous active-high reset
//   flush                 : synchronous kill of every held entry (redirect)
//   in_valid/in_ready     : upstream handshake, in_data is the offered bundle
//   out_valid/out_ready   : downstream handshake, out_data is the held bundle
//   stall_count           : saturating count of cycles with out_valid & ~out_ready
// SKID=1 gives a 2-entry buffer with registered in_ready (no out_ready->in_ready path);
// SKID=0 gives a single register whose in_ready is combinational.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    SKID         = 1,
    parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE = '0,
    parameter int                    CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    occ_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic                  out_valid_q;
    logic                  acc_in_s;
    logic                  acc_out_s;
    logic                  stall_s;

    assign acc_in_s  = in_valid & in_ready;
    assign acc_out_s = out_valid_q & out_ready;
    assign stall_s   = out_valid_q & ~out_ready;

    assign out_valid = out_valid_q;
    assign out_data  = main_q;

    // Main entry, occupancy state and the registered copy of out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= BUBBLE_VALUE;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            out_valid_q <= (state_d != EMPTY);
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_WIDTH-1:0] skid_q, skid_d;
            logic                  in_ready_q;

            // Two-entry occupancy transitions; flush overrides everything.
            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                if (flush) begin
                    state_d = EMPTY;
                    main_d  = BUBBLE_VALUE;
                    skid_d  = BUBBLE_VALUE;
                end else begin
                    case (state_q)
                        EMPTY: begin
                            if (acc_in_s) begin
                                main_d  = in_data;
                                state_d = ONE;
                            end else begin
                                state_d = EMPTY;
                            end
                        end
                        ONE: begin
                            if (acc_in_s && acc_out_s) begin
                                main_d  = in_data;
                                state_d = ONE;
                            end else if (acc_in_s) begin
                                skid_d  = in_data;
                                state_d = FULL;
                            end else if (acc_out_s) begin
                                main_d  = BUBBLE_VALUE;
                                state_d = EMPTY;
                            end else begin
                                state_d = ONE;
                            end
                        end
                        FULL: begin
                            // in_ready is low here, so only the drain can happen.
                            if (acc_out_s) begin
                                main_d  = skid_q;
                                skid_d  = BUBBLE_VALUE;
                                state_d = ONE;
                            end else begin
                                state_d = FULL;
                            end
                        end
                        default: begin
                            state_d = EMPTY;
                            main_d  = BUBBLE_VALUE;
                            skid_d  = BUBBLE_VALUE;
                        end
                    endcase
                end
            end

            // Skid entry plus in_ready computed one cycle ahead from the next state.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    skid_q     <= BUBBLE_VALUE;
                    in_ready_q <= 1'b1;
                end else begin
                    skid_q     <= skid_d;
                    in_ready_q <= (state_d != FULL);
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_noskid
            // Single-entry transitions; accepting while draining keeps full throughput.
            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                if (flush) begin
                    state_d = EMPTY;
                    main_d  = BUBBLE_VALUE;
                end else if (acc_in_s) begin
                    state_d = ONE;
                    main_d  = in_data;
                end else if (acc_out_s) begin
                    state_d = EMPTY;
                    main_d  = BUBBLE_VALUE;
                end else begin
                    state_d = state_q;
                end
            end

            assign in_ready = ~out_valid_q | out_ready;
        end
    endgenerate

    sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (stall_s),
        .count(stall_count)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: SKID=1 instance (32-bit, NOP bubble) driven from a vector table,
// SKID=0 instance (8-bit, 4-bit counter) driven by hand-written sequences.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: SKID=1
    logic        rst_a, flush_a, iv_a, ir_a, ov_a, or_a;
    logic [31:0] din_a, dout_a, st_a;

    pipe_stage_reg #(
        .DATA_WIDTH  (32),
        .SKID        (1),
        .BUBBLE_VALUE(NOP_INSTR),
        .CNT_WIDTH   (32)
    ) dut_a (
        .clk        (clk),
        .rst        (rst_a),
        .flush      (flush_a),
        .in_valid   (iv_a),
        .in_ready   (ir_a),
        .in_data    (din_a),
        .out_valid  (ov_a),
        .out_ready  (or_a),
        .out_data   (dout_a),
        .stall_count(st_a)
    );

    // Instance B: SKID=0
    logic       rst_b, flush_b, iv_b, ir_b, ov_b, or_b;
    logic [7:0] din_b, dout_b;
    logic [3:0] st_b;

    pipe_stage_reg #(
        .DATA_WIDTH  (8),
        .SKID        (0),
        .BUBBLE_VALUE(8'hEE),
        .CNT_WIDTH   (4)
    ) dut_b (
        .clk        (clk),
        .rst        (rst_b),
        .flush      (flush_b),
        .in_valid   (iv_b),
        .in_ready   (ir_b),
        .in_data    (din_b),
        .out_valid  (ov_b),
        .out_ready  (or_b),
        .out_data   (dout_b),
        .stall_count(st_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] din;
        logic        ordy;
        logic        fl;
        logic        eov;
        logic [31:0] eod;
        logic        eir;
        logic [31:0] est;
    } vec_t;

    localparam int NVEC = 17;
    vec_t tbl[NVEC];

    logic [7:0] q[$];
    logic [7:0] exp_b;
    int         n_in, n_out;
    logic       took;

    // Global bound on run length.
    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // iv  din      ordy  fl   | ov  od       ir   stall
        tbl[0]  = '{1'b1, 32'h11, 1'b1, 1'b0, 1'b1, 32'h11, 1'b1, 32'd0};
        tbl[1]  = '{1'b1, 32'h22, 1'b1, 1'b0, 1'b1, 32'h22, 1'b1, 32'd0};
        tbl[2]  = '{1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 32'h33, 1'b1, 32'd0};
        tbl[3]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h13, 1'b1, 32'd0};
        tbl[4]  = '{1'b1, 32'h0A, 1'b0, 1'b0, 1'b1, 32'h0A, 1'b1, 32'd0};
        tbl[5]  = '{1'b1, 32'h0B, 1'b0, 1'b0, 1'b1, 32'h0A, 1'b0, 32'd1};
        tbl[6]  = '{1'b1, 32'h0C, 1'b0, 1'b0, 1'b1, 32'h0A, 1'b0, 32'd2};
        tbl[7]  = '{1'b1, 32'h0C, 1'b0, 1'b0, 1'b1, 32'h0A, 1'b0, 32'd3};
        tbl[8]  = '{1'b1, 32'h0C, 1'b1, 1'b0, 1'b1, 32'h0B, 1'b1, 32'd3};
        tbl[9]  = '{1'b1, 32'h0C, 1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'd3};
        tbl[10] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h13, 1'b1, 32'd3};
        tbl[11] = '{1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 32'h44, 1'b1, 32'd3};
        tbl[12] = '{1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 32'h44, 1'b0, 32'd4};
        tbl[13] = '{1'b1, 32'h0D, 1'b0, 1'b1, 1'b0, 32'h13, 1'b1, 32'd5};
        tbl[14] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h13, 1'b1, 32'd5};
        tbl[15] = '{1'b1, 32'h66, 1'b1, 1'b0, 1'b1, 32'h66, 1'b1, 32'd5};
        tbl[16] = '{1'b1, 32'h77, 1'b1, 1'b1, 1'b0, 32'h13, 1'b1, 32'd5};

        rst_a = 1'b1; flush_a = 1'b0; iv_a = 1'b0; or_a = 1'b0; din_a = 32'h0;
        rst_b = 1'b1; flush_b = 1'b0; iv_b = 1'b0; or_b = 1'b0; din_b = 8'h0;
        #2;
        chk("reset_a_ov", {31'd0, ov_a}, 32'd0);
        chk("reset_a_od", dout_a, 32'h13);
        chk("reset_a_ir", {31'd0, ir_a}, 32'd1);
        chk("reset_a_st", st_a, 32'd0);
        chk("reset_b_ir", {31'd0, ir_b}, 32'd1);
        #10;
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Streaming, backpressure, flush in FULL and flush while draining.
        for (int i = 0; i < NVEC; i++) begin
            iv_a    = tbl[i].iv;
            din_a   = tbl[i].din;
            or_a    = tbl[i].ordy;
            flush_a = tbl[i].fl;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_ov", i), {31'd0, ov_a}, {31'd0, tbl[i].eov});
            chk($sformatf("vec%0d_od", i), dout_a, tbl[i].eod);
            chk($sformatf("vec%0d_ir", i), {31'd0, ir_a}, {31'd0, tbl[i].eir});
            chk($sformatf("vec%0d_st", i), st_a, tbl[i].est);
        end
        flush_a = 1'b0;

        // Asynchronous reset between edges with a live entry.
        iv_a = 1'b1; din_a = 32'h11; or_a = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_ov", {31'd0, ov_a}, 32'd1);
        chk("pre_rst_od", dout_a, 32'h11);
        #2;
        rst_a = 1'b1;
        #1;
        chk("async_rst_ov", {31'd0, ov_a}, 32'd0);
        chk("async_rst_od", dout_a, 32'h13);
        chk("async_rst_st", st_a, 32'd0);
        chk("async_rst_ir", {31'd0, ir_a}, 32'd1);
        iv_a = 1'b0;
        #1;
        rst_a = 1'b0;

        // SKID=0: toggling out_ready with continuous in_valid, then drain.
        @(posedge clk);
        #1;
        din_b = 8'h01;
        n_in = 0;
        n_out = 0;
        for (int c = 0; c < 24; c++) begin
            iv_b = (c < 16);
            or_b = (c >= 16) ? 1'b1 : c[0];
            #1;
            chk($sformatf("noskid_ir_c%0d", c), {31'd0, ir_b}, {31'd0, (~ov_b | or_b)});
            if (ov_b && or_b) begin
                exp_b = (q.size() > 0) ? q.pop_front() : 8'hXX;
                chk($sformatf("noskid_od_c%0d", c), {24'd0, dout_b}, {24'd0, exp_b});
                n_out++;
            end
            took = iv_b & ir_b;
            if (took) begin
                q.push_back(din_b);
                n_in++;
            end
            @(posedge clk);
            #1;
            if (took) din_b = din_b + 8'd1;
        end
        chk("noskid_drained", q.size(), 32'd0);
        chk("noskid_in_eq_out", n_out, n_in);
        chk("noskid_ov_end", {31'd0, ov_b}, 32'd0);
        iv_b = 1'b0;

        // SKID=0 stall counter saturation at 15; flush must not clear it.
        rst_b = 1'b1;
        #1;
        rst_b = 1'b0;
        iv_b = 1'b1; din_b = 8'h5A; or_b = 1'b0;
        @(posedge clk);
        #1;
        iv_b = 1'b0;
        chk("sat_load_ov", {31'd0, ov_b}, 32'd1);
        chk("sat_load_od", {24'd0, dout_b}, 32'h5A);
        chk("sat_st0", {28'd0, st_b}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("sat_st5", {28'd0, st_b}, 32'd5);
        repeat (15) @(posedge clk);
        #1;
        chk("sat_st20", {28'd0, st_b}, 32'd15);
        chk("sat_hold_od", {24'd0, dout_b}, 32'h5A);
        flush_b = 1'b1;
        @(posedge clk);
        #1;
        flush_b = 1'b0;
        chk("sat_flush_ov", {31'd0, ov_b}, 32'd0);
        chk("sat_flush_od", {24'd0, dout_b}, 32'hEE);
        chk("sat_flush_st", {28'd0, st_b}, 32'd15);
        @(posedge clk);
        #1;
        chk("sat_after_st", {28'd0, st_b}, 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
